// File: rtl/wdt_kicker.sv
// wdt_kicker: gathers client heartbeats, pets the watchdog and runs bounded fault recovery
module wdt_kicker #(
  parameter int NUM_CLIENTS    = 4,
  parameter int PET_INTERVAL   = 5000,
  parameter int RECOVER_CYCLES = 16,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_CLIENTS-1:0] heartbeat,
  input  logic                   wdt_irq,
  output logic                   pet,
  output logic                   wdt_rst,
  output logic                   sys_rst_req,
  output logic [NUM_CLIENTS-1:0] missing,
  output logic [7:0]             fault_cnt,
  output logic                   fatal
);
  localparam int CW = $clog2(PET_INTERVAL);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RUN, RECOVER, FATAL} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic [NUM_CLIENTS-1:0] seen, hits;
  logic win_end, rec_done, eval, keep;
  // next state plus window bookkeeping; irq outranks enable, which outranks window evaluation
  always_comb begin
    hits     = seen | heartbeat;
    win_end  = cnt == CW'(PET_INTERVAL - 1);
    rec_done = rcnt == RW'(RECOVER_CYCLES - 1);
    eval     = state == RUN && !wdt_irq && enable && win_end;
    state_n  = state;
    case (state)
      IDLE:    state_n = enable ? RUN : IDLE;
      RUN:     state_n = wdt_irq ? RECOVER : (enable ? RUN : IDLE);
      RECOVER: state_n = !rec_done ? RECOVER :
                         fault_cnt >= 8'(MAX_RETRIES) ? FATAL : (enable ? RUN : IDLE);
      default: state_n = FATAL;
    endcase
    keep = state == RUN && state_n == RUN && !win_end;
  end
  // state, counters and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rcnt        <= '0;
      seen        <= '0;
      pet         <= 1'b0;
      wdt_rst     <= 1'b1;
      sys_rst_req <= 1'b0;
      missing     <= '0;
      fault_cnt   <= '0;
      fatal       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= keep ? cnt + 1'b1 : '0;
      seen        <= keep ? hits : '0;
      rcnt        <= state == RECOVER ? rcnt + 1'b1 : '0;
      pet         <= eval && &hits;
      missing     <= eval ? ~hits : missing;
      fault_cnt   <= (state == RUN && wdt_irq && fault_cnt != 8'hff) ? fault_cnt + 8'd1 : fault_cnt;
      wdt_rst     <= state_n != RUN;
      sys_rst_req <= state_n == RECOVER || state_n == FATAL;
      fatal       <= state_n == FATAL;
    end
  end
endmodule

// File: tb/tb_wdt_kicker.sv
// tb_wdt_kicker: random and directed stimulus against a behavioural watchdog-agent model
module tb_wdt_kicker;
  localparam int NC = 4, PI = 8, RC = 16, MR = 3;
  logic clk = 0, rst = 1, enable = 0, wdt_irq = 0;
  logic [NC-1:0] heartbeat = '0;
  logic pet, wdt_rst, sys_rst_req, fatal;
  logic [NC-1:0] missing;
  logic [7:0] fault_cnt;
  int n_chk = 0, n_pass = 0;
  wdt_kicker #(.NUM_CLIENTS(NC), .PET_INTERVAL(PI), .RECOVER_CYCLES(RC), .MAX_RETRIES(MR)) dut (
    .clk(clk), .rst(rst), .enable(enable), .heartbeat(heartbeat), .wdt_irq(wdt_irq),
    .pet(pet), .wdt_rst(wdt_rst), .sys_rst_req(sys_rst_req), .missing(missing),
    .fault_cnt(fault_cnt), .fatal(fatal)
  );
  always #5 clk = ~clk;
  // model: mode 0 idle, 1 run, 2 recover, 3 fatal
  int m_mode = 0, m_pos = 0, m_rec = 0, m_fault = 0;
  bit m_seen[NC];
  bit e_pet = 0, e_wrst = 1, e_sys = 0, e_fatal = 0;
  bit [NC-1:0] e_missing = '0;
  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask
  task automatic model_step(bit r, bit en, bit [NC-1:0] hb, bit irq);
    int hit_n;
    e_pet = 0;
    if (r) begin
      m_mode = 0; m_fault = 0; e_missing = '0;
    end else if (m_mode == 0) begin
      if (en) begin
        m_mode = 1; m_pos = 0;
        foreach (m_seen[i]) m_seen[i] = 0;
      end
    end else if (m_mode == 1) begin
      if (irq) begin
        m_fault = m_fault < 255 ? m_fault + 1 : 255;
        m_mode = 2; m_rec = 0;
      end else if (!en) m_mode = 0;
      else if (m_pos == PI - 1) begin
        hit_n = 0;
        for (int i = 0; i < NC; i++) begin
          e_missing[i] = !(m_seen[i] || hb[i]);
          if (!e_missing[i]) hit_n++;
          m_seen[i] = 0;
        end
        e_pet = hit_n == NC;
        m_pos = 0;
      end else begin
        m_pos++;
        for (int i = 0; i < NC; i++) if (hb[i]) m_seen[i] = 1;
      end
    end else if (m_mode == 2) begin
      m_rec++;
      if (m_rec == RC) begin
        if (m_fault >= MR) m_mode = 3;
        else if (en) begin
          m_mode = 1; m_pos = 0;
          foreach (m_seen[i]) m_seen[i] = 0;
        end else m_mode = 0;
      end
    end
    e_wrst = m_mode != 1;
    e_sys = m_mode >= 2;
    e_fatal = m_mode == 3;
  endtask
  task automatic cyc(bit r, bit en, bit [NC-1:0] hb, bit irq);
    @(negedge clk);
    rst = r; enable = en; heartbeat = hb; wdt_irq = irq;
    model_step(r, en, hb, irq);
    @(posedge clk);
    #1;
    chk("pet", pet, e_pet);
    chk("wdt_rst", wdt_rst, e_wrst);
    chk("sys_rst_req", sys_rst_req, e_sys);
    chk("missing", missing, e_missing);
    chk("fault_cnt", fault_cnt, m_fault);
    chk("fatal", fatal, e_fatal);
  endtask
  initial begin
    bit en_r;
    bit [NC-1:0] hb;
    cyc(1, 0, '0, 0);
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 3 * PI + 1; i++) cyc(0, 1, 4'hf, 0);
    for (int i = 0; i < PI; i++) cyc(0, 1, i == PI - 1 ? 4'b1011 : 4'b0011, 0);
    for (int i = 0; i < PI; i++) cyc(0, 1, 4'hf, 0);
    for (int i = 0; i < PI - 1; i++) cyc(0, 1, 4'hf, 0);
    cyc(0, 1, 4'hf, 1);
    for (int i = 0; i < RC + 2 * PI; i++) cyc(0, 1, 4'hf, 0);
    cyc(0, 1, 4'b0111, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 1, '0, 0);
    for (int i = 0; i < PI; i++) cyc(0, 1, i == 3 ? 4'b1000 : 4'b0000, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 4'hf, 1);
      for (int i = 0; i < RC + 3; i++) cyc(0, i[0], 4'hf, i == 2);
    end
    for (int i = 0; i < 10; i++) cyc(0, i[0], 4'(i), i[1]);
    cyc(1, 0, '0, 0);
    cyc(0, 1, '0, 0);
    cyc(0, 1, '0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, '0, 0);
    cyc(1, 1, '0, 0);
    en_r = 1;
    for (int n = 0, fat = 0; n < 4000; n++) begin
      en_r = en_r ? ($urandom_range(49) != 0) : ($urandom_range(4) == 0);
      for (int i = 0; i < NC; i++) hb[i] = $urandom_range(3) == 0;
      fat = m_mode == 3 ? fat + 1 : 0;
      cyc($urandom_range(249) == 0 || fat > 20, en_r, hb, $urandom_range(39) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wdt_kicker.md
Name: wdt_kicker

Overview:
Watchdog service agent that sits on the driving side of the wdt block: it owns wdt's pet and rst inputs and consumes wdt's irq output.
- Collects liveness heartbeats from NUM_CLIENTS subsystems and issues a pet only when every client has checked in within the current window.
- On a watchdog irq, runs a bounded recovery sequence: it pulses a system reset request and re-arms the watchdog.
- After MAX_RETRIES faults it locks into a fatal state.

Parameters:
NUM_CLIENTS, 4, number of heartbeat sources (1..32)
PET_INTERVAL, 5000, window length in clk cycles (>=2; must be < wdt TERMINAL_CNT)
RECOVER_CYCLES, 16, cycles sys_rst_req and wdt_rst are held during recovery (>=1)
MAX_RETRIES, 3, number of faults that forces FATAL (1..255)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
enable  input  1  level; 1 = supervise and pet, 0 = hold watchdog in reset
heartbeat  input  NUM_CLIENTS  per-client single-cycle liveness pulses
wdt_irq  input  1  irq from watchdog (latched level)
pet  output  1  single-cycle pet pulse to watchdog
wdt_rst  output  1  reset to watchdog
sys_rst_req  output  1  system reset request
missing  output  NUM_CLIENTS  clients absent in last failed window
fault_cnt  output  8  saturating count of watchdog faults
fatal  output  1  retries exhausted

Behaviour:
- Clock and reset: clock clk; reset rst, synchronous, active-high. All outputs are registered.
- Reset values: state=IDLE, pet=0, wdt_rst=1, sys_rst_req=0, missing=0, fault_cnt=0, fatal=0, interval counter=0, seen mask=0. rst overrides every state, including RECOVER and FATAL.
- States: IDLE, RUN, RECOVER, FATAL.
- IDLE:
  - wdt_rst=1, pet=0.
  - enable=1 -> RUN, with counter=0, seen=0, and wdt_rst=0 in the first RUN cycle.
- RUN, interval counter:
  - Counter counts 0..PET_INTERVAL-1 and wraps.
  - Every cycle, seen <= seen | heartbeat.
- RUN, window end (the cycle with counter==PET_INTERVAL-1):
  - Let hits = seen | heartbeat; a heartbeat arriving on the window-end cycle counts for the ending window.
  - If hits is all ones: pet=1 in the next cycle only, and missing <= 0.
  - Otherwise: no pet, and missing <= ~hits.
  - In both cases seen <= 0 and counter <= 0.
- RUN, pet timing: with continuous compliance, the first pet is high PET_INTERVAL cycles after entering RUN, then once every PET_INTERVAL cycles.
- RUN, priority when events coincide: rst > wdt_irq > enable=0 > window-end evaluation.
- RUN, enable=0 -> IDLE: pet suppressed, seen and counter cleared; missing and fault_cnt retained.
- RUN, wdt_irq=1 -> RECOVER:
  - fault_cnt <= min(fault_cnt+1, 255).
  - No pet, even if the same cycle is a complete window end.
- RECOVER:
  - sys_rst_req=1 and wdt_rst=1 for exactly RECOVER_CYCLES consecutive cycles; pet=0.
  - enable, heartbeat and wdt_irq are ignored.
  - At the end: if fault_cnt >= MAX_RETRIES -> FATAL; else if enable=1 -> RUN with a fresh window (counter=0, seen=0); else -> IDLE.
  - Because wdt_rst is asserted, the watchdog's latched irq clears before RUN resumes.
- FATAL:
  - fatal=1, sys_rst_req=1, wdt_rst=1, pet=0, held indefinitely.
  - Only rst exits FATAL.
- wdt_irq is ignored in IDLE, RECOVER and FATAL.
- Heartbeats are ignored outside RUN. A heartbeat arriving on the enable edge cycle is not counted.
- Width rules: the interval counter is clog2(PET_INTERVAL) bits, the recovery counter is clog2(RECOVER_CYCLES+1) bits, and fault_cnt saturates at 255.

Test Plan:
- NUM_CLIENTS=4, PET_INTERVAL=8, all four clients pulse each window -> pet is a 1-cycle pulse at cycles 8, 16, 24 after RUN entry; missing=0; wdt_rst=0; sys_rst_req=0.
- Client 2 silent for one window, clients 0, 1, 3 pulse (client 3 on the window-end cycle) -> no pet at that boundary and missing=4'b0100; next window fully compliant -> pet pulses and missing=0.
- Single wdt_irq pulse in RUN, RECOVER_CYCLES=16 -> sys_rst_req and wdt_rst high exactly 16 cycles, fault_cnt=1, return to RUN, next pet 8 cycles after recovery ends. wdt_irq coincident with a complete window end -> no pet, RECOVER entered.
- MAX_RETRIES=3, three irqs across recoveries -> after the third recovery, fatal=1 and sys_rst_req=1 held; toggling enable and heartbeat has no effect; rst -> all outputs at reset values next cycle, fault_cnt=0.
- enable dropped mid-window after 3 of 4 clients have pulsed -> IDLE, wdt_rst=1, no pet; re-enable with only client 3 pulsing -> missing=4'b0111, proving pre-drop heartbeats were discarded.
- rst asserted in the middle of RECOVER (cycle 5 of 16) -> next cycle state=IDLE, sys_rst_req=0, wdt_rst=1, fault_cnt=0.
